servo_pan_driver: RTL and testbench

Downstream consumer of the CORDIC atan stage. Takes each signed bearing result (deg, valid pulse) and clips it to the pan servo's ±90° mechanical range. Applies a deadband and per-frame slew limiting, and drives a 50 Hz hobby-servo PWM pulse. Sits between the target-bearing CORDIC and the pan servo pin on the robot camera head.

---
 rtl/cam_servo_pkg.sv | 43 ++++
 rtl/servo_pwm_gen.sv | 58 +++++
 rtl/servo_pan_driver.sv | 119 +++++++++++
 tb/tb_servo_pan_driver.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_servo_pkg.sv
// Shared types and constants for the camera-head pan servo path.
package cam_servo_pkg;

  localparam int unsigned CENTRE_DEG = 90;
  localparam int unsigned CLIP_DEG   = 90;

  typedef logic [7:0] angle_t;

  typedef enum logic {
    HOLD = 1'b0,
    SLEW = 1'b1
  } pan_state_t;

  typedef enum logic [1:0] {
    TK_TPU,
    TK_PERIOD,
    TK_MIN,
    TK_PER_DEG
  } tick_kind_t;

  // Derived clock-tick constants, integer truncation at each step.
  function automatic int unsigned servo_ticks(
    input tick_kind_t  kind,
    input int unsigned clk_freq,
    input int unsigned period_us,
    input int unsigned min_us,
    input int unsigned max_us
  );
    int unsigned tpu;
    int unsigned res;
    tpu = clk_freq / 1_000_000;
    res = tpu;
    case (kind)
      TK_TPU:     res = tpu;
      TK_PERIOD:  res = period_us * tpu;
      TK_MIN:     res = min_us * tpu;
      TK_PER_DEG: res = ((max_us - min_us) * tpu) / 180;
      default:    res = tpu;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/servo_pwm_gen.sv
// Frame counter, width pipeline and registered servo pulse output.
module servo_pwm_gen
  import cam_servo_pkg::*;
#(
  parameter int unsigned PERIOD        = 1_000_000,
  parameter int unsigned MIN_TICKS     = 25_000,
  parameter int unsigned TICKS_PER_DEG = 555
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] angle,
  output logic       pwm,
  output logic       frame_tick,
  output logic       slew_c,
  output logic       end_c
);

  localparam int unsigned CNT_W        = $clog2(PERIOD);
  localparam int unsigned TPD_W        = $clog2(TICKS_PER_DEG + 1);
  localparam int unsigned PROD_W       = 8 + TPD_W;
  localparam int unsigned CENTRE_TICKS = MIN_TICKS + CENTRE_DEG * TICKS_PER_DEG;

  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  width;
  logic [CNT_W-1:0]  width_next;
  logic [PROD_W-1:0] prod_c;
  logic              mul_c;

  assign slew_c = (cnt == CNT_W'(PERIOD - 3));
  assign mul_c  = (cnt == CNT_W'(PERIOD - 2));
  assign end_c  = (cnt == CNT_W'(PERIOD - 1));
  assign prod_c = PROD_W'(angle) * PROD_W'(TICKS_PER_DEG);

  // Period counter, start-of-frame strobe and pulse compare.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt        <= '0;
      frame_tick <= 1'b0;
      pwm        <= 1'b0;
    end else begin
      cnt        <= end_c ? '0 : cnt + CNT_W'(1);
      frame_tick <= end_c;
      pwm        <= (cnt < width);
    end
  end

  // Width computed two cycles before the frame wraps, latched on the last cycle.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      width_next <= CNT_W'(CENTRE_TICKS);
      width      <= CNT_W'(CENTRE_TICKS);
    end else begin
      if (mul_c) width_next <= CNT_W'(MIN_TICKS) + CNT_W'(prod_c);
      if (end_c) width      <= width_next;
    end
  end

endmodule

// File: rtl/servo_pan_driver.sv
// Bearing capture, deadband, slew limiting and timeout for the pan servo.
module servo_pan_driver
  import cam_servo_pkg::*;
#(
  parameter int unsigned CLK_FREQ       = 50_000_000,
  parameter int unsigned PWM_PERIOD_US  = 20000,
  parameter int unsigned PULSE_MIN_US   = 500,
  parameter int unsigned PULSE_MAX_US   = 2500,
  parameter int unsigned SLEW_DEG       = 4,
  parameter int unsigned DEADBAND_DEG   = 2,
  parameter int unsigned TIMEOUT_FRAMES = 50
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       valid,
  input  logic [8:0] deg,
  output logic       pwm,
  output logic [7:0] cur_angle,
  output logic       busy,
  output logic       frame_tick
);

  localparam int unsigned PERIOD = servo_ticks(TK_PERIOD, CLK_FREQ, PWM_PERIOD_US,
                                               PULSE_MIN_US, PULSE_MAX_US);
  localparam int unsigned MIN_TICKS = servo_ticks(TK_MIN, CLK_FREQ, PWM_PERIOD_US,
                                                  PULSE_MIN_US, PULSE_MAX_US);
  localparam int unsigned TICKS_PER_DEG = servo_ticks(TK_PER_DEG, CLK_FREQ, PWM_PERIOD_US,
                                                      PULSE_MIN_US, PULSE_MAX_US);
  localparam int unsigned TO_W = $clog2(TIMEOUT_FRAMES + 1);
  localparam logic signed [8:0] CLIP_HI = 9'(CLIP_DEG);
  localparam logic signed [8:0] CLIP_LO = -9'(CLIP_DEG);

  pan_state_t        state;
  pan_state_t        state_d;
  angle_t            target;
  angle_t            target_d;
  angle_t            cur_d;
  logic [TO_W-1:0]   quiet;
  logic [TO_W-1:0]   quiet_d;
  logic signed [8:0] deg_s;
  logic signed [8:0] clip_c;
  angle_t            cand_c;
  angle_t            gap_c;
  angle_t            slew_gap_c;
  angle_t            step_c;
  logic              slew_c;
  logic              end_c;

  assign deg_s = deg;
  assign busy  = (state == SLEW);

  // Clip bearing to the mechanical range and shift to 0..180.
  always_comb begin
    if (deg_s > CLIP_HI)      clip_c = CLIP_HI;
    else if (deg_s < CLIP_LO) clip_c = CLIP_LO;
    else                      clip_c = deg_s;
    cand_c     = 8'(clip_c + CLIP_HI);
    gap_c      = (cand_c > cur_angle) ? cand_c - cur_angle : cur_angle - cand_c;
    slew_gap_c = (target > cur_angle) ? target - cur_angle : cur_angle - target;
    step_c     = (slew_gap_c > 8'(SLEW_DEG)) ? 8'(SLEW_DEG) : slew_gap_c;
  end

  // Next-state: slew step, capture with deadband, timeout, HOLD/SLEW.
  always_comb begin
    state_d  = state;
    target_d = target;
    cur_d    = cur_angle;
    quiet_d  = quiet;

    if (slew_c) begin
      if (target > cur_angle)      cur_d = cur_angle + step_c;
      else if (target < cur_angle) cur_d = cur_angle - step_c;
    end

    if (valid) begin
      quiet_d = '0;
      if (gap_c > 8'(DEADBAND_DEG)) target_d = cand_c;
    end else if (end_c && (quiet != TO_W'(TIMEOUT_FRAMES))) begin
      quiet_d = quiet + TO_W'(1);
      if (quiet_d == TO_W'(TIMEOUT_FRAMES)) target_d = 8'(CENTRE_DEG);
    end

    case (state)
      HOLD:    if (target_d != cur_d) state_d = SLEW;
      SLEW:    if (target_d == cur_d) state_d = HOLD;
      default: state_d = HOLD;
    endcase
  end

  // State registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= HOLD;
      target    <= 8'(CENTRE_DEG);
      cur_angle <= 8'(CENTRE_DEG);
      quiet     <= '0;
    end else begin
      state     <= state_d;
      target    <= target_d;
      cur_angle <= cur_d;
      quiet     <= quiet_d;
    end
  end

  servo_pwm_gen #(
    .PERIOD        (PERIOD),
    .MIN_TICKS     (MIN_TICKS),
    .TICKS_PER_DEG (TICKS_PER_DEG)
  ) u_pwm (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .angle      (cur_angle),
    .pwm        (pwm),
    .frame_tick (frame_tick),
    .slew_c     (slew_c),
    .end_c      (end_c)
  );

endmodule

// File: tb/tb_servo_pan_driver.sv
// Frame-level scoreboard bench for servo_pan_driver on a scaled-down clock.
module tb_servo_pan_driver;

  localparam int unsigned CLK_FREQ       = 1_000_000;
  localparam int unsigned PWM_PERIOD_US  = 200;
  localparam int unsigned PULSE_MIN_US   = 10;
  localparam int unsigned PULSE_MAX_US   = 190;
  localparam int unsigned SLEW_DEG       = 4;
  localparam int unsigned DEADBAND_DEG   = 2;
  localparam int unsigned TIMEOUT_FRAMES = 8;

  localparam int TPU   = CLK_FREQ / 1_000_000;
  localparam int P     = PWM_PERIOD_US * TPU;
  localparam int MIN_T = PULSE_MIN_US * TPU;
  localparam int TPD   = (PULSE_MAX_US - PULSE_MIN_US) * TPU / 180;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       valid   = 1'b0;
  logic [8:0] deg     = '0;
  logic       pwm;
  logic [7:0] cur_angle;
  logic       busy;
  logic       frame_tick;

  servo_pan_driver #(
    .CLK_FREQ       (CLK_FREQ),
    .PWM_PERIOD_US  (PWM_PERIOD_US),
    .PULSE_MIN_US   (PULSE_MIN_US),
    .PULSE_MAX_US   (PULSE_MAX_US),
    .SLEW_DEG       (SLEW_DEG),
    .DEADBAND_DEG   (DEADBAND_DEG),
    .TIMEOUT_FRAMES (TIMEOUT_FRAMES)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .valid      (valid),
    .deg        (deg),
    .pwm        (pwm),
    .cur_angle  (cur_angle),
    .busy       (busy),
    .frame_tick (frame_tick)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int width;
    int angle;
    int busy;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state, one update per frame.
  int m_target;
  int m_cur;
  int m_quiet;
  bit first_frame;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int cand_of(input int d);
    int c;
    c = d;
    if (c > 90)  c = 90;
    if (c < -90) c = -90;
    return c + 90;
  endfunction

  function automatic int absdiff(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic m_capture(input int d);
    int c;
    c = cand_of(d);
    if (absdiff(c, m_cur) > int'(DEADBAND_DEG)) m_target = c;
    m_quiet = 0;
  endtask

  task automatic m_slew();
    int s;
    s = absdiff(m_target, m_cur);
    if (s > int'(SLEW_DEG)) s = int'(SLEW_DEG);
    if (m_target > m_cur)      m_cur = m_cur + s;
    else if (m_target < m_cur) m_cur = m_cur - s;
  endtask

  // One frame of stimulus; valid (if any) lands on one of the last four cycles.
  task automatic run_frame(input bit v, input int at, input int d, input int rst_at);
    exp_t e;
    int   told;
    int   tnew;
    e.width = MIN_T + m_cur * TPD;
    e.angle = m_cur;
    e.busy  = (m_cur != m_target) ? 1 : 0;
    q.push_back(e);
    for (int c = 0; c < P; c++) begin
      if (c == 0) check("frame_tick_start", int'(frame_tick), first_frame ? 0 : 1);
      if (c == 1) check("frame_tick_low", int'(frame_tick), 0);
      if (c == rst_at) begin
        sys_rst = 1'b1;
        valid   = 1'b0;
        @(negedge sys_clk);
        check("rst_pwm", int'(pwm), 0);
        check("rst_angle", int'(cur_angle), 90);
        check("rst_busy", int'(busy), 0);
        sys_rst     = 1'b0;
        m_target    = 90;
        m_cur       = 90;
        m_quiet     = 0;
        first_frame = 1'b1;
        return;
      end
      valid = v && (c == at);
      deg   = 9'(d);
      @(negedge sys_clk);
    end
    valid       = 1'b0;
    first_frame = 1'b0;

    if (v && at == P - 4) begin
      m_capture(d);
      m_slew();
    end else if (v && at == P - 3) begin
      told = m_target;
      m_capture(d);
      tnew     = m_target;
      m_target = told;
      m_slew();
      m_target = tnew;
    end else begin
      m_slew();
      if (v) m_capture(d);
    end

    if (!(v && at == P - 1)) begin
      if (m_quiet < int'(TIMEOUT_FRAMES)) begin
        m_quiet++;
        if (m_quiet == int'(TIMEOUT_FRAMES)) m_target = 90;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_frame(1'b0, 0, 0, -1);
  endtask

  task automatic hold(input int d, input int n);
    for (int i = 0; i < n; i++)
      run_frame(1'b1, P - 4 + int'($urandom_range(0, 3)), d, -1);
  endtask

  // Monitor: measure each pwm pulse and compare against the scoreboard.
  initial begin : monitor
    int   hi;
    bit   prev;
    exp_t e;
    hi   = 0;
    prev = 1'b0;
    forever begin
      @(posedge sys_clk);
      #1;
      if (pwm === 1'b1) begin
        hi++;
        prev = 1'b1;
      end else begin
        if (prev) begin
          if (q.size() == 0) begin
            check("pulse_unexpected", hi, 0);
          end else begin
            e = q.pop_front();
            check("pulse_width", hi, e.width);
            check("pulse_angle", int'(cur_angle), e.angle);
            check("pulse_busy", int'(busy), e.busy);
          end
        end
        prev = 1'b0;
        hi   = 0;
      end
    end
  end

  // Stimulus: directed scenarios followed by random bearings.
  initial begin : driver
    int r;
    m_target    = 90;
    m_cur       = 90;
    m_quiet     = 0;
    first_frame = 1'b1;
    sys_rst     = 1'b1;
    repeat (3) @(negedge sys_clk);
    check("reset_pwm", int'(pwm), 0);
    check("reset_angle", int'(cur_angle), 90);
    check("reset_busy", int'(busy), 0);
    check("reset_tick", int'(frame_tick), 0);
    sys_rst = 1'b0;

    idle(3);

    hold(45, 14);

    hold(-180, 36);
    hold(170, 47);

    idle(33);
    run_frame(1'b1, P - 4, 1, -1);
    run_frame(1'b1, P - 3, -2, -1);
    run_frame(1'b1, P - 4, 3, -1);
    idle(2);

    hold(45, 12);
    run_frame(1'b1, P - 4, 45, -1);
    idle(int'(TIMEOUT_FRAMES) - 2);
    run_frame(1'b1, P - 1, 45, -1);
    idle(3);
    idle(int'(TIMEOUT_FRAMES) + 12);

    hold(-180, 5);
    run_frame(1'b1, P - 4, -180, P / 2);
    idle(2);

    for (int i = 0; i < 120; i++) begin
      r = int'($urandom_range(0, 3));
      if (r == 0) idle(1);
      else run_frame(1'b1, P - 4 + int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 359)) - 180, -1);
    end

    repeat (2) @(negedge sys_clk);
    check("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
